argon_bus_sequencer: RTL
========================

Name: argon_bus_sequencer

Overview:
- Micro-sequencer that owns the shared datapath bus.
- Accepts one register-to-register ALU operation per valid/ready handshake.
- Sequences it as single-cycle bus transfers by driving read_id, write_id and the ALU/RegFile strobes: select registers, load opcode, move operands into the ALU, write the result back.
- Sits between instruction decode and the bus mux, taking over the ID and strobe ports currently driven from the simulation top.

Parameters:
- WORD_W, 16, bus word width
- OP_W, 4, ALU opcode width
- REG_W, 4, register index width

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  operation request valid
- o_req_ready  out  1  sequencer idle, can accept a request
- i_req_op  in  OP_W  ALU opcode
- i_req_rd  in  REG_W  destination register
- i_req_rs1  in  REG_W  source A register
- i_req_rs2  in  REG_W  source B register
- i_req_unary  in  1  skip the operand B transfer
- i_req_nowb  in  1  skip write-back (compare-type operation)
- i_bus_valid  in  1  master bus o_valid, observed by the sequencer
- o_read_id  out  4  bus source ID
- o_write_id  out  4  bus destination ID
- o_ctrl_data  out  WORD_W  data the sequencer drives when it is bus source (ID_CTRL)
- o_ctrl_valid  out  1  o_ctrl_data valid
- o_selectLatch, o_outputA, o_outputB, o_latchC  out  1 each  RegFile strobes
- o_latchA, o_latchB, o_latchOp, o_outputY  out  1 each  ALU strobes
- o_latchF, o_outputF  out  1 each  ALU flag strobes; held 0 by this version
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse, operation completed
- o_err  out  1  one-cycle pulse, operation aborted

Behaviour:
- Moore FSM. State is registered; all ID and strobe outputs are decoded from the state plus the captured request.
- States: IDLE, SEL, OP, RD_A, RD_B, WB.
- Reset:
  - state = IDLE; captured request cleared.
  - o_done = 0, o_err = 0, o_busy = 0.
  - All strobes 0; o_ctrl_valid = 0.
  - o_read_id = o_write_id = ID_NONE (4'hF).
- o_req_ready = (state == IDLE) && !i_Reset.
- Accept occurs at the clock edge where i_req_valid && o_req_ready. All request fields are captured; IDLE -> SEL.
- SEL:
  - read_id = ID_CTRL, write_id = ID_REGFILE, o_ctrl_valid = 1.
  - o_ctrl_data = {zeros, rd[11:8], rs2[7:4], rs1[3:0]}.
  - o_selectLatch = 1. Next state OP.
- OP:
  - read_id = ID_CTRL, write_id = ID_ALU, o_ctrl_data = zero-extended op, o_ctrl_valid = 1.
  - o_latchOp = 1. Next state RD_A.
- RD_A:
  - read_id = ID_REGFILE, write_id = ID_ALU, o_outputA = 1.
  - o_latchA = o_outputA && i_bus_valid.
  - Next state RD_B; if unary, WB; if unary and nowb, IDLE with done.
- RD_B:
  - read_id = ID_REGFILE, write_id = ID_ALU, o_outputB = 1.
  - o_latchB gated by i_bus_valid.
  - Next state WB, or IDLE with done if nowb.
- WB:
  - read_id = ID_ALU, write_id = ID_REGFILE, o_outputY = 1.
  - o_latchC gated by i_bus_valid.
  - Next state IDLE with done.
- Bus check:
  - In RD_A, RD_B and WB, i_bus_valid = 0 aborts: the latch strobe is suppressed, next state IDLE, o_err pulses.
  - o_done is never asserted for an aborted operation.
- o_done / o_err are registered pulses. They are high in the first IDLE cycle, where o_req_ready is also high, so back-to-back requests are allowed.
- Latency from the accept edge to o_done, inclusive of the done cycle:
  - binary + wb: 6 cycles
  - unary + wb: 5 cycles
  - binary + nowb: 5 cycles
  - unary + nowb: 4 cycles
- i_req_valid outside IDLE is ignored; the request is not captured.
- Reset mid-operation: IDLE on the next cycle, no done or err pulse, strobes deasserted in that cycle.
- Exactly one source and at most one destination strobe is active per cycle. IDs are ID_NONE in IDLE.

Decomposition:
- argon_pkg additions:
  - ID_CTRL and ID_NONE bus-ID constants
  - seq_state_t enum
  - seq_req_t struct {op, rd, rs1, rs2, unary, nowb}
  - SEL_* field-offset localparams for the select-word packing
- No sub-module: a single FSM plus request register.

Test Plan:
- Reset, then idle: o_req_ready = 1, IDs = 4'hF, all strobes 0, o_done = o_err = 0.
- Binary op=3, rs1=1, rs2=2, rd=5, bus valid:
  - SEL drives o_ctrl_data = 16'h0521 with selectLatch.
  - OP drives 16'h0003 with latchOp.
  - Then latchA, latchB, latchC on consecutive cycles.
  - o_done is high 6 cycles after accept.
- Unary + nowb: the RD_B and WB states never appear; o_done is high 4 cycles after accept.
- i_bus_valid = 0 in RD_B: latchB stays 0, o_err pulses next cycle, no o_done, no latchC.
- Back-to-back: the second request is accepted in the o_done cycle and its SEL follows immediately, with no gap cycle.
- i_Reset asserted in RD_A: IDLE next cycle, no done or err pulse; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/argon_bus_sequencer_pkg.sv
// Shared types and constants for the bus sequencer: bus IDs, FSM states, captured request
// and the packing of the register-select word.
package argon_bus_sequencer_pkg;

  localparam int unsigned ARGON_WORD_W = 16;
  localparam int unsigned ARGON_OP_W   = 4;
  localparam int unsigned ARGON_REG_W  = 4;

  localparam logic [3:0] ID_REGFILE = 4'h1;
  localparam logic [3:0] ID_ALU     = 4'h2;
  localparam logic [3:0] ID_CTRL    = 4'h3;
  localparam logic [3:0] ID_NONE    = 4'hF;

  localparam int unsigned SEL_RS1_LSB = 0;
  localparam int unsigned SEL_RS2_LSB = 4;
  localparam int unsigned SEL_RD_LSB  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StOp,
    StRdA,
    StRdB,
    StWb
  } seq_state_t;

  typedef struct packed {
    logic [ARGON_OP_W-1:0]  op;
    logic [ARGON_REG_W-1:0] rd;
    logic [ARGON_REG_W-1:0] rs1;
    logic [ARGON_REG_W-1:0] rs2;
    logic                   unary;
    logic                   nowb;
  } seq_req_t;

  function automatic logic [ARGON_WORD_W-1:0] packSelect(seq_req_t req);
    logic [ARGON_WORD_W-1:0] word;
    word = '0;
    word[SEL_RD_LSB  +: ARGON_REG_W] = req.rd;
    word[SEL_RS2_LSB +: ARGON_REG_W] = req.rs2;
    word[SEL_RS1_LSB +: ARGON_REG_W] = req.rs1;
    return word;
  endfunction

endpackage

// File: rtl/argon_bus_sequencer_if.sv
// Request handshake plus bus ID/strobe bundle between decode (master) and the sequencer (slave).
interface argon_bus_sequencer_if #(
  parameter int unsigned WORD_W = argon_bus_sequencer_pkg::ARGON_WORD_W,
  parameter int unsigned OP_W   = argon_bus_sequencer_pkg::ARGON_OP_W,
  parameter int unsigned REG_W  = argon_bus_sequencer_pkg::ARGON_REG_W
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [OP_W-1:0]   i_req_op;
  logic [REG_W-1:0]  i_req_rd;
  logic [REG_W-1:0]  i_req_rs1;
  logic [REG_W-1:0]  i_req_rs2;
  logic              i_req_unary;
  logic              i_req_nowb;
  logic              i_bus_valid;
  logic [3:0]        o_read_id;
  logic [3:0]        o_write_id;
  logic [WORD_W-1:0] o_ctrl_data;
  logic              o_ctrl_valid;
  logic              o_selectLatch;
  logic              o_outputA;
  logic              o_outputB;
  logic              o_latchC;
  logic              o_latchA;
  logic              o_latchB;
  logic              o_latchOp;
  logic              o_outputY;
  logic              o_latchF;
  logic              o_outputF;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_req_valid, i_req_op, i_req_rd, i_req_rs1, i_req_rs2, i_req_unary, i_req_nowb,
    output i_bus_valid,
    input  o_req_ready, o_read_id, o_write_id, o_ctrl_data, o_ctrl_valid,
    input  o_selectLatch, o_outputA, o_outputB, o_latchC, o_latchA, o_latchB, o_latchOp,
    input  o_outputY, o_latchF, o_outputF, o_busy, o_done, o_err
  );

  modport slave (
    input  i_req_valid, i_req_op, i_req_rd, i_req_rs1, i_req_rs2, i_req_unary, i_req_nowb,
    input  i_bus_valid,
    output o_req_ready, o_read_id, o_write_id, o_ctrl_data, o_ctrl_valid,
    output o_selectLatch, o_outputA, o_outputB, o_latchC, o_latchA, o_latchB, o_latchOp,
    output o_outputY, o_latchF, o_outputF, o_busy, o_done, o_err
  );

endinterface

// File: rtl/argon_bus_sequencer.sv
// Bus micro-sequencer: turns one accepted ALU request into a chain of single-cycle bus
// transfers (select, opcode, operand A, operand B, write-back).
module argon_bus_sequencer
  import argon_bus_sequencer_pkg::*;
(
  input logic                  i_Clk,
  input logic                  i_Reset,
  argon_bus_sequencer_if.slave bus
);

  seq_state_t stateQ;
  seq_req_t   reqQ;
  logic       doneQ;
  logic       errQ;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stateQ <= StIdle;
      reqQ   <= '0;
      doneQ  <= 1'b0;
      errQ   <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      errQ  <= 1'b0;
      unique case (stateQ)
        StIdle: begin
          if (bus.i_req_valid) begin
            reqQ <= '{op: bus.i_req_op, rd: bus.i_req_rd, rs1: bus.i_req_rs1,
                      rs2: bus.i_req_rs2, unary: bus.i_req_unary, nowb: bus.i_req_nowb};
            stateQ <= StSel;
          end
        end
        StSel: stateQ <= StOp;
        StOp:  stateQ <= StRdA;
        StRdA: begin
          if (!bus.i_bus_valid) begin
            stateQ <= StIdle;
            errQ   <= 1'b1;
          end else if (reqQ.unary && reqQ.nowb) begin
            stateQ <= StIdle;
            doneQ  <= 1'b1;
          end else begin
            stateQ <= reqQ.unary ? StWb : StRdB;
          end
        end
        StRdB: begin
          if (!bus.i_bus_valid) begin
            stateQ <= StIdle;
            errQ   <= 1'b1;
          end else if (reqQ.nowb) begin
            stateQ <= StIdle;
            doneQ  <= 1'b1;
          end else begin
            stateQ <= StWb;
          end
        end
        StWb: begin
          stateQ <= StIdle;
          if (bus.i_bus_valid) doneQ <= 1'b1;
          else                 errQ  <= 1'b1;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  // Destination latches only fire when the source actually put a valid word on the bus.
  always_comb begin
    bus.o_read_id     = ID_NONE;
    bus.o_write_id    = ID_NONE;
    bus.o_ctrl_data   = '0;
    bus.o_ctrl_valid  = 1'b0;
    bus.o_selectLatch = 1'b0;
    bus.o_outputA     = 1'b0;
    bus.o_outputB     = 1'b0;
    bus.o_latchC      = 1'b0;
    bus.o_latchA      = 1'b0;
    bus.o_latchB      = 1'b0;
    bus.o_latchOp     = 1'b0;
    bus.o_outputY     = 1'b0;
    unique case (stateQ)
      StSel: begin
        bus.o_read_id     = ID_CTRL;
        bus.o_write_id    = ID_REGFILE;
        bus.o_ctrl_data   = packSelect(reqQ);
        bus.o_ctrl_valid  = 1'b1;
        bus.o_selectLatch = 1'b1;
      end
      StOp: begin
        bus.o_read_id    = ID_CTRL;
        bus.o_write_id   = ID_ALU;
        bus.o_ctrl_data  = ARGON_WORD_W'(reqQ.op);
        bus.o_ctrl_valid = 1'b1;
        bus.o_latchOp    = 1'b1;
      end
      StRdA: begin
        bus.o_read_id  = ID_REGFILE;
        bus.o_write_id = ID_ALU;
        bus.o_outputA  = 1'b1;
        bus.o_latchA   = bus.i_bus_valid;
      end
      StRdB: begin
        bus.o_read_id  = ID_REGFILE;
        bus.o_write_id = ID_ALU;
        bus.o_outputB  = 1'b1;
        bus.o_latchB   = bus.i_bus_valid;
      end
      StWb: begin
        bus.o_read_id  = ID_ALU;
        bus.o_write_id = ID_REGFILE;
        bus.o_outputY  = 1'b1;
        bus.o_latchC   = bus.i_bus_valid;
      end
      default: ;
    endcase
  end

  assign bus.o_latchF    = 1'b0;
  assign bus.o_outputF   = 1'b0;
  assign bus.o_busy      = (stateQ != StIdle);
  assign bus.o_req_ready = (stateQ == StIdle) && !i_Reset;
  assign bus.o_done      = doneQ;
  assign bus.o_err       = errQ;

endmodule
